// File: rtl/gcd_pkg.sv
// Shared types and default widths for the GCD controller and the gcd_dp datapath.
package gcd_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ITER_WIDTH_DEF = 8;
   localparam int MAX_ITER_DEF   = 200;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      COMPUTE = 3'd2,
      FINISH  = 3'd3,
      RESP    = 3'd4
   } gcd_state_e;

   // Layout of gcd_dp's gcd_o; the controller consumes only the result field.
   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] result;
      logic                      done;
   } gcd_data;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Saturating compute-cycle counter with synchronous clear and a terminal-count flag.
module gcd_iter_cnt
   import gcd_pkg::*;
#(
   parameter int ITER_WIDTH = ITER_WIDTH_DEF,
   parameter int MAX_ITER   = MAX_ITER_DEF
) (
   input  logic                  clk_i,
   input  logic                  nreset_i,
   input  logic                  clear,
   input  logic                  enable,
   output logic [ITER_WIDTH-1:0] count,
   output logic                  terminal
);

   localparam logic [ITER_WIDTH-1:0] TERM_VAL = ITER_WIDTH'(MAX_ITER - 1);

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == TERM_VAL);

endmodule

// File: rtl/gcd_ctrl.sv
// Request/response front-end that sequences gcd_dp through init, compute and finish.
module gcd_ctrl
   import gcd_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ITER_WIDTH = ITER_WIDTH_DEF,
   parameter int MAX_ITER   = MAX_ITER_DEF
) (
   input  logic                  clk_i,
   input  logic                  nreset_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [DATA_WIDTH-1:0] req_a_i,
   input  logic [DATA_WIDTH-1:0] req_b_i,
   output logic [DATA_WIDTH-1:0] operand_a_o,
   output logic [DATA_WIDTH-1:0] operand_b_o,
   output logic                  gcd_enable_o,
   output logic                  flag_init_o,
   output logic                  flag_compute_o,
   output logic                  flag_finish_o,
   input  logic                  compare_zero_i,
   input  logic [DATA_WIDTH-1:0] gcd_result_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_data_o,
   output logic [ITER_WIDTH-1:0] resp_iter_o,
   output logic                  resp_timeout_o
);

   gcd_state_e            state_q, state_d;
   logic                  timeout_q;
   logic                  accept;
   logic [ITER_WIDTH-1:0] iter_count;
   logic                  iter_terminal;

   assign accept = req_valid_i && req_ready_o;

   gcd_iter_cnt #(
      .ITER_WIDTH (ITER_WIDTH),
      .MAX_ITER   (MAX_ITER)
   ) u_iter_cnt (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .clear    (accept),
      .enable   (state_q == COMPUTE),
      .count    (iter_count),
      .terminal (iter_terminal)
   );

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Timeout is only flagged when the limit, not compare_zero, ends COMPUTE.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         operand_a_o <= '0;
         operand_b_o <= '0;
         timeout_q   <= 1'b0;
      end else if (accept) begin
         operand_a_o <= req_a_i;
         operand_b_o <= req_b_i;
         timeout_q   <= 1'b0;
      end else if ((state_q == COMPUTE) && !compare_zero_i && iter_terminal) begin
         timeout_q   <= 1'b1;
      end
   end

   // NOTE: every output and next-state is given a default first so no path infers a latch.
   always_comb begin
      state_d        = state_q;
      req_ready_o    = 1'b0;
      gcd_enable_o   = 1'b0;
      flag_init_o    = 1'b0;
      flag_compute_o = 1'b0;
      flag_finish_o  = 1'b0;
      resp_valid_o   = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = INIT;
         end
         INIT: begin
            flag_init_o  = 1'b1;
            gcd_enable_o = 1'b1;
            state_d      = compare_zero_i ? FINISH : COMPUTE;
         end
         COMPUTE: begin
            flag_compute_o = 1'b1;
            gcd_enable_o   = 1'b1;
            if (compare_zero_i || iter_terminal) state_d = FINISH;
         end
         FINISH: begin
            flag_finish_o = 1'b1;
            state_d       = RESP;
         end
         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign resp_data_o    = resp_valid_o ? gcd_result_i : '0;
   assign resp_iter_o    = resp_valid_o ? iter_count   : '0;
   assign resp_timeout_o = resp_valid_o && timeout_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl driving a small Euclid model of gcd_dp.
module tb_gcd_ctrl;

   localparam int DW       = 8;
   localparam int IW       = 8;
   localparam int MAX_ITER = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic [IW-1:0] iter;
      logic          timeout;
      int            acc;
   } exp_t;

   logic          clk_i = 1'b0;
   logic          nreset_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [DW-1:0] req_a_i, req_b_i;
   logic [DW-1:0] operand_a_o, operand_b_o;
   logic          gcd_enable_o, flag_init_o, flag_compute_o, flag_finish_o;
   logic          compare_zero_i;
   logic [DW-1:0] gcd_result_i;
   logic          resp_valid_o, resp_ready_i;
   logic [DW-1:0] resp_data_o;
   logic [IW-1:0] resp_iter_o;
   logic          resp_timeout_o;

   gcd_ctrl #(.DATA_WIDTH(DW), .ITER_WIDTH(IW), .MAX_ITER(MAX_ITER)) dut (
      .clk_i          (clk_i),
      .nreset_i       (nreset_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_a_i        (req_a_i),
      .req_b_i        (req_b_i),
      .operand_a_o    (operand_a_o),
      .operand_b_o    (operand_b_o),
      .gcd_enable_o   (gcd_enable_o),
      .flag_init_o    (flag_init_o),
      .flag_compute_o (flag_compute_o),
      .flag_finish_o  (flag_finish_o),
      .compare_zero_i (compare_zero_i),
      .gcd_result_i   (gcd_result_i),
      .resp_valid_o   (resp_valid_o),
      .resp_ready_i   (resp_ready_i),
      .resp_data_o    (resp_data_o),
      .resp_iter_o    (resp_iter_o),
      .resp_timeout_o (resp_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // cz_mode 0: datapath model decides; 1: never zero; 2: zero at compute cycle cz_at (0 = INIT)
   int            cz_mode = 0;
   int            cz_at = 0;
   logic [DW-1:0] dp_a, dp_b, dp_res;
   int            comp_cnt;

   always @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         dp_a <= '0; dp_b <= '0; dp_res <= '0; comp_cnt <= 0;
      end else begin
         if (flag_init_o) begin
            dp_a <= operand_a_o; dp_b <= operand_b_o; comp_cnt <= 0;
         end else if (flag_compute_o) begin
            comp_cnt <= comp_cnt + 1;
            if (dp_a != 0 && dp_b != 0) begin
               dp_a <= dp_b;
               dp_b <= dp_a % dp_b;
            end
         end
         if (flag_finish_o) dp_res <= (dp_a == 0) ? dp_b : dp_a;
      end
   end

   assign gcd_result_i = dp_res;

   always_comb begin
      case (cz_mode)
         0:       compare_zero_i = flag_init_o ? (operand_a_o == 0 || operand_b_o == 0)
                                               : (dp_a == 0 || dp_b == 0);
         1:       compare_zero_i = 1'b0;
         default: compare_zero_i = (flag_init_o && cz_at == 0) ||
                                   (flag_compute_o && (comp_cnt + 1 == cz_at));
      endcase
   end

   function automatic exp_t predict(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input int mode, input int at);
      exp_t          e;
      logic [DW-1:0] x, y, t;
      bit            cz;
      x = a; y = b;
      e.iter = '0; e.timeout = 1'b0; e.acc = 0;
      cz = (mode == 0) ? (a == 0 || b == 0) : (mode == 2 && at == 0);
      if (!cz) begin
         for (int c = 1; c <= MAX_ITER; c++) begin
            cz = (mode == 0) ? (x == 0 || y == 0) : (mode == 2 && c == at);
            e.iter = IW'(c);
            if (!cz && c == MAX_ITER) e.timeout = 1'b1;
            if (x != 0 && y != 0) begin
               t = y; y = x % y; x = t;
            end
            if (cz) break;
         end
      end
      e.data = (x == 0) ? y : x;
      return e;
   endfunction

   exp_t sb[$];
   int   last_acc = 0;
   int   hs_cyc = 0;
   int   first_cyc = 0;
   int   resp_count = 0;
   int   flag_err = 0;
   int   n_comp = 0, n_init = 0, n_fin = 0;
   bit   rv_prev = 1'b0;

   always @(negedge clk_i) begin
      exp_t e;
      if (!nreset_i) begin
         n_comp = 0; n_init = 0; n_fin = 0; rv_prev = 1'b0;
      end else begin
         if ($countones({flag_init_o, flag_compute_o, flag_finish_o, resp_valid_o, req_ready_o}) != 1)
            flag_err++;
         if (gcd_enable_o != (flag_init_o || flag_compute_o)) flag_err++;
         if (flag_compute_o) n_comp++;
         if (flag_init_o) n_init++;
         if (flag_finish_o) n_fin++;
         if (resp_valid_o && !rv_prev) first_cyc = cyc;
         rv_prev = resp_valid_o;
         if (resp_valid_o && resp_ready_i) begin
            resp_count++;
            hs_cyc = cyc;
            if (sb.size() == 0) begin
               check("unexpected_resp", 1, 0);
            end else begin
               e = sb.pop_front();
               check("resp_data", resp_data_o, e.data);
               check("resp_iter", resp_iter_o, e.iter);
               check("resp_timeout", resp_timeout_o, e.timeout);
               check("compute_cycles", n_comp, e.iter);
               check("init_cycles", n_init, 1);
               check("finish_cycles", n_fin, 1);
               check("latency", first_cyc - e.acc, 3 + e.iter);
            end
            n_comp = 0; n_init = 0; n_fin = 0;
         end
      end
   end

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input int mode, input int at);
      exp_t e;
      bit   ok = 1'b0;
      cz_mode = mode; cz_at = at;
      req_a_i = a; req_b_i = b; req_valid_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (req_ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         check("accept_timeout", 0, 1);
         req_valid_i = 1'b0;
         return;
      end
      e = predict(a, b, mode, at);
      e.acc = cyc;
      last_acc = cyc;
      sb.push_back(e);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      check("operand_a", operand_a_o, a);
      check("operand_b", operand_b_o, b);
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk_i); #1;
         if (sb.size() == 0 && req_ready_o) return;
      end
      check("drain_timeout", sb.size(), 0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_req_ready"}, req_ready_o, 1);
      check({pfx, "_flags"}, {flag_init_o, flag_compute_o, flag_finish_o, gcd_enable_o}, 0);
      check({pfx, "_operands"}, {operand_a_o, operand_b_o}, 0);
      check({pfx, "_resp"}, {resp_valid_o, resp_data_o, resp_iter_o, resp_timeout_o}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int saved;
      bit seen;
      nreset_i = 1'b0; req_valid_i = 1'b0; req_a_i = '0; req_b_i = '0; resp_ready_i = 1'b1;
      #12;
      check_reset_outputs("in_reset");
      @(posedge clk_i); #1;
      nreset_i = 1'b1;
      repeat (2) @(negedge clk_i);
      check_reset_outputs("idle");

      // 12,8: compare_zero on the 3rd COMPUTE cycle, result 4
      @(posedge clk_i); #1;
      send(8'd12, 8'd8, 0, 0);
      drain();

      // 0,5: zero operand, COMPUTE skipped
      send(8'd0, 8'd5, 0, 0);
      drain();

      // timeout, then compare_zero on the last allowed cycle
      send(8'd12, 8'd8, 1, 0);
      drain();
      send(8'd12, 8'd8, 2, MAX_ITER);
      drain();

      // response back-pressure with a pending request
      resp_ready_i = 1'b0;
      send(8'd12, 8'd8, 0, 0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (resp_valid_o) begin seen = 1'b1; break; end
      end
      check("hold_resp_seen", seen, 1);
      @(posedge clk_i); #1;
      fork
         send(8'd9, 8'd6, 0, 0);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk_i);
               check("hold_valid", resp_valid_o, 1);
               check("hold_data", resp_data_o, 4);
               check("hold_iter", resp_iter_o, 3);
               check("hold_timeout", resp_timeout_o, 0);
               check("hold_req_ready", req_ready_o, 0);
            end
            @(posedge clk_i); #1;
            resp_ready_i = 1'b1;
         end
      join
      check("accept_after_release", last_acc, hs_cyc + 1);

      // back-to-back follow-up request
      saved = last_acc;
      send(8'd7, 8'd7, 0, 0);
      check("b2b_spacing", last_acc - saved, 4 + 3);
      drain();

      // reset asserted mid-COMPUTE
      send(8'd12, 8'd8, 1, 0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (flag_compute_o) begin seen = 1'b1; break; end
      end
      check("abort_compute_seen", seen, 1);
      #1;
      nreset_i = 1'b0;
      #1;
      check_reset_outputs("abort");
      sb.delete();
      saved = resp_count;
      repeat (2) @(posedge clk_i);
      #1;
      nreset_i = 1'b1;
      repeat (10) @(posedge clk_i);
      #1;
      check("no_resp_after_abort", resp_count, saved);
      check("idle_after_abort", req_ready_o, 1);

      check("protocol_errors", flag_err, 0);
      check("scoreboard_empty", sb.size(), 0);
      check("response_count", resp_count, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
